// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Accepts one operation per three cycles: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (pulse).
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_inst,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_inst,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_pos,
  output logic [OPW-1:0]   alu_inst_id,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   inst_q, inst_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             pos_q, pos_d;

  logic gnt0, gnt1, accept;

  // last_grant_q == 1 means requester 1 won last, so requester 0 wins a tie
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_grant_q);
    gnt1 = req1_valid & ~gnt0;
  end

  assign req0_ready = (state_q == S_IDLE) & gnt0 & ~reset;
  assign req1_ready = (state_q == S_IDLE) & gnt1 & ~reset;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    inst_d       = inst_q;
    in0_d        = in0_q;
    in1_d        = in1_q;
    data_d       = data_q;
    zero_d       = zero_q;
    pos_d        = pos_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_EXEC;
          owner_d      = gnt1;
          last_grant_d = gnt1;
          inst_d       = gnt1 ? req1_inst : req0_inst;
          in0_d        = gnt1 ? req1_a    : req0_a;
          in1_d        = gnt1 ? req1_b    : req0_b;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        data_d  = alu_out;
        zero_d  = (alu_out == '0);
        pos_d   = ~alu_out[WIDTH-1] & (|alu_out);
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      inst_q       <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      pos_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      inst_q       <= inst_d;
      in0_q        <= in0_d;
      in1_q        <= in1_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      pos_q        <= pos_d;
    end
  end

  // Reset in the RESP cycle suppresses the pulse of the in-flight operation
  assign resp0_valid = (state_q == S_RESP) & ~owner_q & ~reset;
  assign resp1_valid = (state_q == S_RESP) &  owner_q & ~reset;

  assign resp_data   = data_q;
  assign resp_zero   = zero_q;
  assign resp_pos    = pos_q;
  assign alu_inst_id = inst_q;
  assign alu_in0     = in0_q;
  assign alu_in1     = in1_q;

endmodule
